// File: rtl/bist_seq_ctrl.sv
// Logic-BIST sequencer: drives scan enable through shift/capture windows,
// counts patterns, flushes the last response into the MISR and checks the
// final signature against a golden value.
`timescale 1ns/1ps
module bist_seq_ctrl #(
  parameter int unsigned         SIG_LEN    = 13,
  parameter int unsigned         CHAIN_LEN  = 16,
  parameter int unsigned         PAT_NUM    = 4,
  parameter logic [SIG_LEN-1:0]  GOLDEN_SIG = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [SIG_LEN-1:0]               sig,
  output logic                             test_se,
  output logic                             misr_rst_n,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [$clog2(PAT_NUM+1)-1:0]     pat_cnt
);

  localparam int unsigned PCW = $clog2(PAT_NUM + 1);
  localparam int unsigned SCW = $clog2(CHAIN_LEN + 1);

  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] PAT_MAX    = PCW'(PAT_NUM);
  localparam logic [PCW-1:0] PAT_LAST   = PCW'(PAT_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [SCW-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PCW-1:0]   pat_cnt_q, pat_cnt_d;
  logic             pass_q, pass_d;
  logic             test_se_q, test_se_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        pat_cnt_d   = '0;
        shift_cnt_d = '0;
        pass_d      = 1'b0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = S_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + SCW'(1);
        end
      end
      S_CAPTURE: begin
        shift_cnt_d = '0;
        pat_cnt_d   = (pat_cnt_q == PAT_MAX) ? PAT_MAX : pat_cnt_q + PCW'(1);
        // Next load overlaps the unload of this response; the last one needs a pure flush.
        state_d     = (pat_cnt_q < PAT_LAST) ? S_SHIFT : S_UNLOAD;
      end
      S_UNLOAD: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = S_CHECK;
        end else begin
          shift_cnt_d = shift_cnt_q + SCW'(1);
        end
      end
      S_CHECK: begin
        pass_d  = (sig == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase

    test_se_d = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
      test_se_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
      test_se_q   <= test_se_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // MISR is held clear during reset and for the single INIT cycle.
  assign misr_rst_n = ~(rst | (state_q == S_INIT));

  assign test_se = test_se_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign pat_cnt = pat_cnt_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Bench for bist_seq_ctrl: vector table, directed run sequences, random
// stimulus against a run-offset reference model, and a minimal-size instance.
`timescale 1ns/1ps
module tb_bist_seq_ctrl;

  localparam int unsigned CL  = 16;
  localparam int unsigned P   = 4;
  localparam logic [12:0] G   = 13'h1A5;
  localparam int          RUN = P * (CL + 1) + CL + 2;   // edges from start to done

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [12:0] sig;
  logic        test_se, misr_rst_n, busy, done, pass;
  logic [2:0]  pat_cnt;

  logic        rst2, start2;
  logic [12:0] sig2;
  logic        test_se2, misr_rst_n2, busy2, done2, pass2;
  logic [0:0]  pat_cnt2;

  bist_seq_ctrl #(.SIG_LEN(13), .CHAIN_LEN(CL), .PAT_NUM(P), .GOLDEN_SIG(G)) dut (
    .clk(clk), .rst(rst), .start(start), .sig(sig), .test_se(test_se),
    .misr_rst_n(misr_rst_n), .busy(busy), .done(done), .pass(pass), .pat_cnt(pat_cnt)
  );

  bist_seq_ctrl #(.SIG_LEN(13), .CHAIN_LEN(1), .PAT_NUM(1), .GOLDEN_SIG(13'h0)) dut_small (
    .clk(clk), .rst(rst2), .start(start2), .sig(sig2), .test_se(test_se2),
    .misr_rst_n(misr_rst_n2), .busy(busy2), .done(done2), .pass(pass2), .pat_cnt(pat_cnt2)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase (0 idle, 1 running, 2 done) and edge offset k since start.
  int m_st = 0, m_k = 0, m_pass = 0, m_pat_init = 0;

  task automatic model_step(input logic r, input logic s, input logic [12:0] sg);
    if (r) begin
      m_st = 0; m_k = 0; m_pass = 0;
    end else begin
      case (m_st)
        0: if (s) begin m_st = 1; m_k = 0; m_pat_init = 0; end
        1: begin
          if (m_k == 0) m_pass = 0;
          if (m_k == RUN - 1) begin
            m_pass = (sg == G) ? 1 : 0;
            m_st   = 2;
          end else m_k++;
        end
        default: if (s) begin m_st = 1; m_k = 0; m_pat_init = P; end
      endcase
    end
  endtask

  function automatic int exp_se();
    if (m_st != 1 || m_k < 1 || m_k > RUN - 2) return 0;
    if ((m_k - 1) >= P * (CL + 1)) return 1;
    return (((m_k - 1) % (CL + 1)) < CL) ? 1 : 0;
  endfunction

  function automatic int exp_pat();
    int n;
    if (m_st == 0) return 0;
    if (m_st == 2) return P;
    if (m_k == 0) return m_pat_init;
    n = (m_k - 1) / (CL + 1);
    return (n > P) ? P : n;
  endfunction

  task automatic model_check();
    chk("test_se", test_se, exp_se());
    chk("busy", busy, (m_st == 1) ? 1 : 0);
    chk("done", done, (m_st == 2) ? 1 : 0);
    chk("pass", pass, m_pass);
    chk("pat_cnt", pat_cnt, exp_pat());
    chk("misr_rst_n", misr_rst_n, (rst || (m_st == 1 && m_k == 0)) ? 0 : 1);
  endtask

  // One clock: apply inputs, advance model, check after the edge.
  task automatic cyc(input logic r, input logic s, input logic [12:0] sg);
    rst = r; start = s; sig = sg;
    @(posedge clk);
    model_step(r, s, sg);
    #1;
    model_check();
  endtask

  // Start a run from idle/done and wait (bounded) for done.
  task automatic run_to_done(input logic hold, input logic [12:0] sg, input int repulse_at,
                             output int lat, output int se_hi, output int misr_lo);
    cyc(1'b0, 1'b1, sg);
    lat = 0; se_hi = 0; misr_lo = (misr_rst_n == 1'b0) ? 1 : 0;
    for (int n = 1; n <= 300; n++) begin
      cyc(1'b0, hold || (n == repulse_at), sg);
      if (test_se) se_hi++;
      if (!misr_rst_n) misr_lo++;
      if (done) begin lat = n; break; end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic [12:0] sig;
    logic        e_se;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic        e_misr;
    logic [2:0]  e_pat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, se_hi, misr_lo;
    logic [12:0] rs;
    logic e_se2 [6];
    logic e_done2 [6];
    logic e_pat2 [6];
    logic e_misr2 [6];
    logic e_busy2 [6];

    vecs[0] = '{1'b1, 1'b0, 13'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 13'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 13'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 13'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[4] = '{1'b0, 1'b0, 13'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{1'b0, 1'b1, G,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{1'b1, 1'b0, G,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7] = '{1'b0, 1'b0, G,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};

    e_se2   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_done2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_pat2  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    e_misr2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_busy2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sig = '0;
    rst2 = 1'b1; start2 = 1'b0; sig2 = '0;

    // Vector table: reset, start, ignored start, early reset.
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rst, vecs[i].start, vecs[i].sig);
      chk("vec_se", test_se, vecs[i].e_se);
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_done", done, vecs[i].e_done);
      chk("vec_pass", pass, vecs[i].e_pass);
      chk("vec_misr", misr_rst_n, vecs[i].e_misr);
      chk("vec_pat", pat_cnt, vecs[i].e_pat);
    end

    // Full run with matching signature.
    run_to_done(1'b0, G, -1, lat, se_hi, misr_lo);
    chk("run1_latency", lat, RUN);
    chk("run1_se_high", se_hi, (P + 1) * CL);
    chk("run1_misr_low", misr_lo, 1);
    chk("run1_pass", pass, 1);
    chk("run1_pat", pat_cnt, P);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 13'h0);

    // Mismatching signature.
    run_to_done(1'b0, 13'h1A4, -1, lat, se_hi, misr_lo);
    chk("run2_latency", lat, RUN);
    chk("run2_pass", pass, 0);
    chk("run2_done", done, 1);

    // Start re-pulsed mid-run is ignored.
    run_to_done(1'b0, G, 30, lat, se_hi, misr_lo);
    chk("repulse_latency", lat, RUN);
    chk("repulse_pass", pass, 1);

    // Start held high: back-to-back runs, pass cleared in INIT.
    run_to_done(1'b1, 13'h0ABC, -1, lat, se_hi, misr_lo);
    chk("held_latency", lat, RUN);
    cyc(1'b0, 1'b1, G);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_misr", misr_rst_n, 0);
    cyc(1'b0, 1'b0, G);
    chk("held_pass_cleared", pass, 0);
    chk("held_se", test_se, 1);
    for (int i = 0; i < RUN; i++) cyc(1'b0, 1'b0, G);
    chk("held_run2_done", done, 1);
    chk("held_run2_pass", pass, 1);

    // Reset mid-shift at cycle 40, then a full run.
    cyc(1'b0, 1'b1, G);
    for (int i = 1; i < 40; i++) cyc(1'b0, 1'b0, G);
    cyc(1'b1, 1'b0, G);
    chk("midrst_se", test_se, 0);
    chk("midrst_pat", pat_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_misr", misr_rst_n, 0);
    cyc(1'b0, 1'b0, G);
    run_to_done(1'b0, G, -1, lat, se_hi, misr_lo);
    chk("midrst_latency", lat, RUN);
    chk("midrst_se_high", se_hi, (P + 1) * CL);

    // Random stimulus checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(1, 0) == 1) ? G : 13'($urandom);
      cyc(($urandom_range(199, 0) == 0), ($urandom_range(39, 0) == 0), rs);
    end

    // Minimal instance: PAT_NUM=1, CHAIN_LEN=1.
    cyc(1'b0, 1'b0, G);
    rst2 = 1'b0; start2 = 1'b1;
    cyc(1'b0, 1'b0, G);
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc(1'b0, 1'b0, G);
      chk("small_se", test_se2, e_se2[i]);
      chk("small_done", done2, e_done2[i]);
      chk("small_pat", pat_cnt2, e_pat2[i]);
      chk("small_misr", misr_rst_n2, e_misr2[i]);
      chk("small_busy", busy2, e_busy2[i]);
    end
    chk("small_pass", pass2, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
